// File: rtl/reg_bus_pkg.sv
// Shared constants, state encoding and register address map for the register bus arbiter.
package reg_bus_pkg;

  localparam logic [15:0] REG0_ADDR = 16'h0011;
  localparam logic [15:0] REG1_ADDR = 16'h0022;
  localparam logic [15:0] REG2_ADDR = 16'h0033;
  localparam logic [15:0] REG3_ADDR = 16'h0044;
  localparam int          NUM_REGS  = 4;
  localparam int          WCNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [15:0] reg_addr(input int idx);
    case (idx)
      0:       reg_addr = REG0_ADDR;
      1:       reg_addr = REG1_ADDR;
      2:       reg_addr = REG2_ADDR;
      3:       reg_addr = REG3_ADDR;
      default: reg_addr = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/reg_bus_decode.sv
// Combinational address decode to a one-hot register select.
// REG_BUS_ALIAS8_EN: when defined, only addr[7:0] is compared (aliasing every 256 bytes).
module reg_bus_decode
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_sel,
  output logic                o_hit
);

  logic [15:0] w_key;

  // Compare the latched address against each register's fixed address.
  always_comb begin
    o_sel = '0;
    w_key = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_key = reg_addr(i);
`ifdef REG_BUS_ALIAS8_EN
      if (i_addr[7:0] == w_key[7:0]) begin
        o_sel[i] = 1'b1;
      end else begin
        o_sel[i] = 1'b0;
      end
`else
      if (i_addr == ADDR_W'(w_key)) begin
        o_sel[i] = 1'b1;
      end else begin
        o_sel[i] = 1'b0;
      end
`endif
    end
    o_hit = |o_sel;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter and sequencer owning a 4 x DATA_W register bank.
// Decode aliasing is selected by REG_BUS_ALIAS8_EN (see reg_bus_decode).
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYC);

  state_e              r_state, w_next;
  logic [WCNT_W-1:0]   r_cnt;
  logic                r_last, r_id, r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_bank [NUM_REGS];
  logic                w_grant, w_id, w_hit, w_resp_go;
  logic [NUM_REGS-1:0] w_sel;
  logic [DATA_W-1:0]   w_rd, w_rdata_d;
  logic                w_ack0_d, w_ack1_d, w_err_d, w_busy_d;
  logic                r_ack0, r_ack1, r_err, r_busy;
  logic [DATA_W-1:0]   r_rdata;

  reg_bus_decode #(.ADDR_W(ADDR_W)) u_decode (
    .i_addr (r_addr),
    .o_sel  (w_sel),
    .o_hit  (w_hit)
  );

  // Round-robin winner: on a tie, the requester not granted last time.
  always_comb begin
    w_grant = req0 | req1;
    if (req0 && req1) begin
      w_id = ~r_last;
    end else if (req1) begin
      w_id = 1'b1;
    end else begin
      w_id = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next = ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_next = RESP;
        end else begin
          w_next = ACCESS;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Transaction latch, wait counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= 1'b1;
    end else if (r_state == IDLE && w_grant) begin
      r_cnt   <= WAIT_LD;
      r_id    <= w_id;
      r_we    <= w_id ? we1 : we0;
      r_addr  <= w_id ? addr1 : addr0;
      r_wdata <= w_id ? wdata1 : wdata0;
    end else if (r_state == ACCESS && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == RESP) begin
      r_last <= r_id;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Register bank; written only as RESP retires a write hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (r_state == RESP && r_we && w_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_sel[i]) begin
          r_bank[i] <= r_wdata;
        end else begin
          r_bank[i] <= r_bank[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= r_bank[i];
      end
    end
  end

  // Next values of the response outputs, loaded on the ACCESS->RESP edge.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd = w_rd | (r_bank[i] & {DATA_W{w_sel[i]}});
    end
    w_resp_go = (r_state == ACCESS) && (r_cnt == '0);
    w_ack0_d  = w_resp_go && !r_id;
    w_ack1_d  = w_resp_go && r_id;
    w_err_d   = w_resp_go && !w_hit;
    if (w_resp_go && w_hit && !r_we) begin
      w_rdata_d = w_rd;
    end else begin
      w_rdata_d = '0;
    end
    w_busy_d = (w_next != IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack0  <= w_ack0_d;
      r_ack1  <= w_ack1_d;
      r_err   <= w_err_d;
      r_rdata <= w_rdata_d;
      r_busy  <= w_busy_d;
    end
  end

  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = r_busy;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomized self-checking bench: three arbiters (WAIT_CYC = 1, 0, 15) against a transaction-level model.
module tb_reg_bus_arbiter;

  localparam int NI = 3;
  localparam int WC [NI] = '{1, 0, 15};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_s [NI];
  logic        we0_s [NI];
  logic [15:0] addr0_s [NI];
  logic [7:0]  wdata0_s [NI];
  logic        ack0_s [NI];
  logic        req1_s [NI];
  logic        we1_s [NI];
  logic [15:0] addr1_s [NI];
  logic [7:0]  wdata1_s [NI];
  logic        ack1_s [NI];
  logic [7:0]  rdata_s [NI];
  logic        err_s [NI];
  logic        busy_s [NI];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  bank_m [NI][4];
  logic        last_m [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYC(WC[g])) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0_s[g]),
      .we0    (we0_s[g]),
      .addr0  (addr0_s[g]),
      .wdata0 (wdata0_s[g]),
      .ack0   (ack0_s[g]),
      .req1   (req1_s[g]),
      .we1    (we1_s[g]),
      .addr1  (addr1_s[g]),
      .wdata1 (wdata1_s[g]),
      .ack1   (ack1_s[g]),
      .rdata  (rdata_s[g]),
      .err    (err_s[g]),
      .busy   (busy_s[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register n lives at 0x11*(n+1); returns -1 on a miss.
  function automatic int ref_idx(input logic [15:0] a);
    int x;
    x = int'(a);
`ifdef REG_BUS_ALIAS8_EN
    x = x % 256;
`endif
    for (int i = 0; i < 4; i++) begin
      if (x == 17 * (i + 1)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      last_m[k] = 1'b1;
      for (int i = 0; i < 4; i++) bank_m[k][i] = 8'h00;
    end
  endtask

  task automatic chk_quiet(input string tag, input int k, input logic exp_busy);
    chk({tag, "_busy"}, 32'(busy_s[k]), 32'(exp_busy));
    chk({tag, "_out"}, {21'd0, ack0_s[k], ack1_s[k], err_s[k], rdata_s[k]}, 32'd0);
  endtask

  // One transaction on instance k; reqs are driven at a negedge, sampled at edge 1.
  task automatic run(input int k, input logic r0, input logic r1,
                     input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                     input logic w1, input logic [15:0] a1, input logic [7:0] d1,
                     input logic drop);
    int   win, idx, lat;
    logic we;
    logic [7:0] d, exp_rd;
    logic got;
    if (r0 && r1) win = last_m[k] ? 0 : 1;
    else win = r1 ? 1 : 0;
    we     = win ? w1 : w0;
    d      = win ? d1 : d0;
    idx    = ref_idx(win ? a1 : a0);
    exp_rd = (idx >= 0 && !we) ? bank_m[k][idx] : 8'h00;
    lat    = WC[k] + 2;
    got    = 1'b0;
    @(negedge clk);
    req0_s[k] = r0; we0_s[k] = w0; addr0_s[k] = a0; wdata0_s[k] = d0;
    req1_s[k] = r1; we1_s[k] = w1; addr1_s[k] = a1; wdata1_s[k] = d1;
    for (int e = 1; e <= 40 && !got; e++) begin
      @(posedge clk); #1;
      if (drop && e == 1) begin
        req0_s[k] = 1'b0;
        req1_s[k] = 1'b0;
      end
      if (ack0_s[k] || ack1_s[k]) begin
        got = 1'b1;
        chk("latency", 32'(e), 32'(lat));
        chk("ack0", 32'(ack0_s[k]), 32'(win == 0));
        chk("ack1", 32'(ack1_s[k]), 32'(win == 1));
        chk("rdata", 32'(rdata_s[k]), 32'(exp_rd));
        chk("err", 32'(err_s[k]), 32'(idx < 0));
        chk("busy_resp", 32'(busy_s[k]), 32'd1);
      end else begin
        chk("busy_wait", 32'(busy_s[k]), 32'd1);
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    req0_s[k] = 1'b0;
    req1_s[k] = 1'b0;
    if (idx >= 0 && we) bank_m[k][idx] = d;
    last_m[k] = win[0];
    @(posedge clk); #1;
    chk_quiet("after_ack", k, 1'b0);
  endtask

  // Both requesters held continuously: acks alternate with exactly one IDLE cycle between.
  task automatic tie_run(input int k, input int n, input logic [15:0] a);
    int lat, next_e, cnt, win, idx;
    lat    = WC[k] + 2;
    next_e = lat;
    cnt    = 0;
    idx    = ref_idx(a);
    @(negedge clk);
    req0_s[k] = 1'b1; we0_s[k] = 1'b0; addr0_s[k] = a;
    req1_s[k] = 1'b1; we1_s[k] = 1'b0; addr1_s[k] = a;
    for (int e = 1; e <= 200 && cnt < n; e++) begin
      @(posedge clk); #1;
      if (ack0_s[k] || ack1_s[k]) begin
        win = last_m[k] ? 0 : 1;
        chk("b2b_edge", 32'(e), 32'(next_e));
        chk("b2b_ack0", 32'(ack0_s[k]), 32'(win == 0));
        chk("b2b_ack1", 32'(ack1_s[k]), 32'(win == 1));
        chk("b2b_rdata", 32'(rdata_s[k]), 32'(idx >= 0 ? bank_m[k][idx] : 8'h00));
        chk("b2b_err", 32'(err_s[k]), 32'(idx < 0));
        last_m[k] = win[0];
        cnt++;
        next_e = e + lat + 1;
      end
    end
    if (cnt < n) chk("b2b_timeout", 32'(cnt), 32'(n));
    req0_s[k] = 1'b0;
    req1_s[k] = 1'b0;
    @(posedge clk); #1;
    chk_quiet("b2b_after", k, 1'b0);
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0, 1, 2, 3: return 16'(17 * (r + 1));
      4:          return 16'h0111;
      5:          return 16'h1011;
      6:          return 16'hFF11;
      default:    return 16'($urandom);
    endcase
  endfunction

  initial begin
    int          k;
    logic        r0, r1;
    for (int i = 0; i < NI; i++) begin
      req0_s[i] = 1'b0; we0_s[i] = 1'b0; addr0_s[i] = 16'h0000; wdata0_s[i] = 8'h00;
      req1_s[i] = 1'b0; we1_s[i] = 1'b0; addr1_s[i] = 16'h0000; wdata1_s[i] = 8'h00;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk_quiet("reset", i, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) chk_quiet("idle", i, 1'b0);

    // Directed: first read, write/read-back, untouched registers.
    run(0, 1'b1, 1'b0, 1'b0, 16'h0011, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
    run(0, 1'b1, 1'b0, 1'b1, 16'h0022, 8'hA5, 1'b0, 16'h0000, 8'h00, 1'b0);
    run(0, 1'b1, 1'b0, 1'b0, 16'h0022, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run(0, 1'b1, 1'b0, 1'b0, 16'(17 * (i + 1)), 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
    end
    tie_run(0, 4, 16'h0033);

    // Decode width: requester 1 reads 0x0111 on every wait-state setting.
    for (int i = 0; i < NI; i++) begin
      run(i, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0111, 8'h00, 1'b0);
      run(i, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h1011, 8'h00, 1'b0);
    end
    tie_run(1, 3, 16'h0022);
    tie_run(2, 2, 16'h0044);

    // Random traffic including ties, misses, writes and dropped requests.
    for (int t = 0; t < 80; t++) begin
      k  = $urandom_range(0, NI - 1);
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      run(k, r0, r1, 1'($urandom), rand_addr(), 8'($urandom),
          1'($urandom), rand_addr(), 8'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Reset in ACCESS aborts a write to 0x0044.
    @(negedge clk);
    req0_s[2] = 1'b1; we0_s[2] = 1'b1; addr0_s[2] = 16'h0044; wdata0_s[2] = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pre_busy", 32'(busy_s[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_async", 2, 1'b0);
    req0_s[2] = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {30'd0, ack0_s[2], ack1_s[2]}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(2, 1'b1, 1'b1, 1'b0, 16'h0044, 8'h00, 1'b0, 16'h0044, 8'h00, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0044, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
